display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner_pkg.sv | 11 +
 rtl/tick_divider.sv | 20 ++
 rtl/display_scanner.sv | 90 +++++++++
 tb/tb_display_scanner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// display_scanner_pkg: shared constants and helpers for the multiplexed display scanner.
package display_scanner_pkg;
   localparam int NUM_DIGITS = 4;
   localparam int NIBBLE_W = 4;
   localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'b1111;
   localparam int DEF_DIV = 12000;
   localparam int DEF_GUARD = 2;
   function automatic logic [NUM_DIGITS-1:0] digit_on(input logic [$clog2(NUM_DIGITS)-1:0] idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..DIV-1 prescaler; tick marks the last count of each period.
module tick_divider
   import display_scanner_pkg::*;
#(
   parameter int DIV = DEF_DIV
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic [$clog2(DIV)-1:0]  count,
   output logic                    tick
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] r_count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_count <= '0;
      else        r_count <= tick ? '0 : r_count + CW'(1);
   end
   assign count = r_count;
   assign tick = r_count == CW'(DIV - 1);
endmodule

// File: rtl/display_scanner.sv
// display_scanner: 4-digit multiplexed display scanner with frame-synchronous double-buffered loads.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN.
module display_scanner
   import display_scanner_pkg::*;
#(
   parameter int DIV   = DEF_DIV,
   parameter int GUARD = DEF_GUARD
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_DIGITS*NIBBLE_W-1:0] value_in,
   input  logic                           load,
   input  logic [NUM_DIGITS-1:0]          dp_in,
   output logic                           load_ack,
   output logic [NIBBLE_W-1:0]            digit_nibble,
   output logic [NUM_DIGITS-1:0]          digit_sel,
   output logic                           dp_out,
   output logic                           frame_start
);
   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int VW = NUM_DIGITS * NIBBLE_W;
   logic [CW-1:0]         w_count;
   logic                  w_tick;
   logic                  w_wrap;
   logic                  w_blank;
   logic [IW-1:0]         r_index;
   logic [VW-1:0]         r_shadow;
   logic [VW-1:0]         r_active;
   logic [NUM_DIGITS-1:0] r_shadow_dp;
   logic [NUM_DIGITS-1:0] r_active_dp;
   logic                  r_pending;

   tick_divider #(.DIV(DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .count (w_count),
      .tick  (w_tick)
   );

   assign w_wrap = w_tick && (r_index == IW'(NUM_DIGITS - 1));

`ifdef DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN
   // A digit is blank when it and every more-significant digit are zero.
   assign w_blank = (r_index != '0) && ((r_active >> {r_index, 2'b00}) == '0);
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_index     <= '0;
         frame_start <= 1'b0;
         load_ack    <= 1'b0;
      end else begin
         r_index     <= w_tick ? r_index + IW'(1) : r_index;
         frame_start <= w_wrap;
         load_ack    <= load;
      end
   end

   // Active copy at the wrap sees the pre-load shadow, so a colliding load stays pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_active    <= '0;
         r_active_dp <= '0;
         r_pending   <= 1'b0;
      end else begin
         r_shadow    <= load ? value_in : r_shadow;
         r_shadow_dp <= load ? dp_in : r_shadow_dp;
         r_active    <= (w_wrap && r_pending) ? r_shadow : r_active;
         r_active_dp <= (w_wrap && r_pending) ? r_shadow_dp : r_active_dp;
         r_pending   <= load || (r_pending && !w_wrap);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_nibble <= '0;
         digit_sel    <= DIGIT_OFF;
         dp_out       <= 1'b0;
      end else begin
         digit_nibble <= r_active[{r_index, 2'b00} +: NIBBLE_W];
         digit_sel    <= ((w_count < CW'(GUARD)) || w_blank) ? DIGIT_OFF : digit_on(r_index);
         dp_out       <= r_active_dp[r_index];
      end
   end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: table-driven, scoreboarded bench for display_scanner at DIV=4, GUARD=2.
module tb_display_scanner;
   import display_scanner_pkg::*;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  mask;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic        load_ack;
   logic [3:0]  digit_nibble;
   logic [3:0]  digit_sel;
   logic        dp_out;
   logic        frame_start;

   int   tests = 0;
   int   fails = 0;
   vec_t exp_q[$];
   vec_t tbl[5];

   display_scanner #(.DIV(4), .GUARD(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .value_in     (value_in),
      .load         (load),
      .dp_in        (dp_in),
      .load_ack     (load_ack),
      .digit_nibble (digit_nibble),
      .digit_sel    (digit_sel),
      .dp_out       (dp_out),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Steps at least one negedge and stops at the negedge where frame_start is high.
   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 40);
      chk("frame_start_seen", 32'(frame_start), 1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value_in = v;
      dp_in = d;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk($sformatf("load_ack_%h", v), 32'(load_ack), 1);
   endtask

   // Called at a frame_start negedge; checks the 16 output samples of the frame.
   task automatic check_frame(input string tag);
      vec_t e;
      logic [3:0] es;
      chk({tag, "_queued"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         es = ((j % 4) < 2 || !e.mask[j/4]) ? 4'b1111 : ~(4'b0001 << (j/4));
         chk($sformatf("%s_sel%0d", tag, j), 32'(digit_sel), 32'(es));
         chk($sformatf("%s_nib%0d", tag, j), 32'(digit_nibble), 32'(e.value[(j/4)*4 +: 4]));
         chk($sformatf("%s_dp%0d", tag, j), 32'(dp_out), 32'(e.dp[j/4]));
         if (j == 0) chk({tag, "_fs_pulse"}, 32'(frame_start), 0);
      end
   endtask

   initial begin
      tbl[0] = '{16'h1234, 4'b0100, 4'b1111};
`ifdef DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN
      tbl[1] = '{16'h0007, 4'b0001, 4'b0001};
      tbl[2] = '{16'h0000, 4'b0000, 4'b0001};
      tbl[3] = '{16'h0103, 4'b1010, 4'b0111};
`else
      tbl[1] = '{16'h0007, 4'b0001, 4'b1111};
      tbl[2] = '{16'h0000, 4'b0000, 4'b1111};
      tbl[3] = '{16'h0103, 4'b1010, 4'b1111};
`endif
      tbl[4] = '{16'hFEDC, 4'b1001, 4'b1111};

      #1 rst_n = 1'b0;
      #1;
      chk("rst_sel", 32'(digit_sel), 32'hF);
      chk("rst_nib", 32'(digit_nibble), 0);
      chk("rst_dp", 32'(dp_out), 0);
      chk("rst_ack", 32'(load_ack), 0);
      chk("rst_fs", 32'(frame_start), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_frame();

      for (int i = 0; i < 5; i++) begin
         do_load(tbl[i].value, tbl[i].dp);
         exp_q.push_back(tbl[i]);
         @(negedge clk);
         chk($sformatf("ack_drop%0d", i), 32'(load_ack), 0);
         wait_frame();
         check_frame($sformatf("vec%0d", i));
      end

      do_load(16'hAAAA, 4'b1111);
      do_load(16'h5555, 4'b0000);
      exp_q.push_back('{16'h5555, 4'b0000, 4'b1111});
      wait_frame();
      check_frame("dbl");

      do_load(16'h1111, 4'b0011);
      exp_q.push_back('{16'h1111, 4'b0011, 4'b1111});
      repeat (14) @(negedge clk);
      do_load(16'h9999, 4'b1100);
      exp_q.push_back('{16'h9999, 4'b1100, 4'b1111});
      chk("col_on_wrap", 32'(frame_start), 1);
      check_frame("col1");
      check_frame("col2");
      chk("col_pending_clear", 32'(dut.r_pending), 0);

      repeat (2) @(negedge clk);
      value_in = 16'h8765;
      dp_in = 4'b1111;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("pre_rst_sel", 32'(digit_sel), 32'hE);
      chk("pre_rst_ack", 32'(load_ack), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", 32'(digit_sel), 32'hF);
      chk("mid_rst_nib", 32'(digit_nibble), 0);
      chk("mid_rst_dp", 32'(dp_out), 0);
      chk("mid_rst_ack", 32'(load_ack), 0);
      chk("mid_rst_fs", 32'(frame_start), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_digit0_sel", 32'(digit_sel), 32'hE);
      chk("post_rst_digit0_nib", 32'(digit_nibble), 0);
`ifdef DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN
      exp_q.push_back('{16'h0000, 4'b0000, 4'b0001});
`else
      exp_q.push_back('{16'h0000, 4'b0000, 4'b1111});
`endif
      wait_frame();
      check_frame("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
